cm_sort: RTL and testbench

- Fully pipelined combinational-sort network. Sorts a vector of DCNT unsigned DWIDTH-bit elements into ascending order, smallest at index 0.
- Generic datapath primitive in the cm library. Accepts one vector per cycle with no backpressure.
- Presents the sorted vector exactly REG_CNT cycles after input, qualified by a valid strobe.

---
 rtl/cm_pkg.sv | 10 +
 rtl/cm_sort_cmp_swap.sv | 25 ++
 rtl/cm_sort.sv | 77 +++++++
 tb/tb_cm_sort.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// Shared helpers for the cm datapath library.
package cm_pkg;

    // True when a pipeline register follows compare-exchange layer l of a
    // dcnt-layer network carrying reg_cnt evenly spread register stages.
    function automatic logic reg_after_layer(input int l, input int dcnt, input int reg_cnt);
        return (((l + 32'sd1) * reg_cnt) / dcnt) > ((l * reg_cnt) / dcnt);
    endfunction

endpackage

// File: rtl/cm_sort_cmp_swap.sv
// Combinational compare-exchange: lo = min(a,b), hi = max(a,b), unsigned.
// Equal inputs are passed straight through so the network stays stable.
module cm_sort_cmp_swap #(
    parameter int DWIDTH = 16
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] lo,
    output logic [DWIDTH-1:0] hi
);

    // Swap only when b is strictly smaller than a.
    always_comb begin
        lo = a;
        hi = b;
        if (b < a) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

// File: rtl/cm_sort.sv
// Pipelined odd-even transposition sorter: DCNT layers of compare-exchange,
// REG_CNT register stages spread evenly, the last layer always registered.
module cm_sort
    import cm_pkg::*;
#(
    parameter int DCNT    = 8,
    parameter int DWIDTH  = 16,
    parameter int REG_CNT = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_vld,
    input  logic [DCNT*DWIDTH-1:0] i_data,
    output logic                   o_vld,
    output logic [DCNT*DWIDTH-1:0] o_data
);

    for (genvar l = 0; l < DCNT; l++) begin : g_layer
        localparam int PAR = l % 2;

        logic [DCNT-1:0][DWIDTH-1:0] in_s;
        logic                        in_vld_s;
        logic [DCNT-1:0][DWIDTH-1:0] cx_s;
        logic [DCNT-1:0][DWIDTH-1:0] out_s;
        logic                        out_vld_s;

        if (l == 0) begin : g_src_in
            assign in_s     = i_data;
            assign in_vld_s = i_vld;
        end else begin : g_src_prev
            assign in_s     = g_layer[l-1].out_s;
            assign in_vld_s = g_layer[l-1].out_vld_s;
        end

        // Pairs (j, j+1) start at the layer parity; unpaired ends pass through.
        for (genvar j = 0; j < DCNT; j++) begin : g_elem
            localparam bit IS_LO = (j >= PAR) && (((j - PAR) % 2) == 0) && (j + 1 < DCNT);
            localparam bit IS_HI = (j > PAR) && (((j - 1 - PAR) % 2) == 0);
            if (IS_LO) begin : g_cx
                cm_sort_cmp_swap #(.DWIDTH(DWIDTH)) u_cx (
                    .a  (in_s[j]),
                    .b  (in_s[j+1]),
                    .lo (cx_s[j]),
                    .hi (cx_s[j+1])
                );
            end else if (!IS_HI) begin : g_pass
                assign cx_s[j] = in_s[j];
            end
        end

        if (reg_after_layer(l, DCNT, REG_CNT)) begin : g_reg
            logic [DCNT-1:0][DWIDTH-1:0] data_r;
            logic                        vld_r;

            // Stage register: data loads every cycle, valid shifts alongside.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    data_r <= '0;
                    vld_r  <= 1'b0;
                end else begin
                    data_r <= cx_s;
                    vld_r  <= in_vld_s;
                end
            end

            assign out_s     = data_r;
            assign out_vld_s = vld_r;
        end else begin : g_comb
            assign out_s     = cx_s;
            assign out_vld_s = in_vld_s;
        end
    end

    assign o_data = g_layer[DCNT-1].out_s;
    assign o_vld  = g_layer[DCNT-1].out_vld_s;

endmodule

// File: tb/tb_cm_sort.sv
// Self-checking bench for cm_sort: five parameterisations share one stimulus
// stream; a delay-line scoreboard compares each output against a software sort.
module tb_cm_sort;

    localparam int NI = 5;
    localparam int DC [NI] = '{4, 6, 10, 8, 4};
    localparam int RC [NI] = '{1, 2, 4, 3, 4};
    localparam int HN = 4096;

    typedef logic [9:0][15:0] vec_t;

    typedef struct {
        int   inst;
        vec_t in_v;
        vec_t exp_v;
    } tvec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cur_vld = 1'b0;
    vec_t cur_vec = '0;

    logic [63:0]  od0;
    logic [95:0]  od1;
    logic [159:0] od2;
    logic [127:0] od3;
    logic [63:0]  od4;
    logic         ov [NI];
    logic [159:0] out_flat [NI];

    logic hist_vld [HN];
    vec_t hist_vec [HN];
    int   pcnt = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    cm_sort #(.DCNT(4), .DWIDTH(16), .REG_CNT(1)) u_d4r1 (
        .i_clk(clk), .i_rst(rst), .i_vld(cur_vld), .i_data(cur_vec[3:0]), .o_vld(ov[0]), .o_data(od0));
    cm_sort #(.DCNT(6), .DWIDTH(16), .REG_CNT(2)) u_d6r2 (
        .i_clk(clk), .i_rst(rst), .i_vld(cur_vld), .i_data(cur_vec[5:0]), .o_vld(ov[1]), .o_data(od1));
    cm_sort #(.DCNT(10), .DWIDTH(16), .REG_CNT(4)) u_d10r4 (
        .i_clk(clk), .i_rst(rst), .i_vld(cur_vld), .i_data(cur_vec), .o_vld(ov[2]), .o_data(od2));
    cm_sort #(.DCNT(8), .DWIDTH(16), .REG_CNT(3)) u_d8r3 (
        .i_clk(clk), .i_rst(rst), .i_vld(cur_vld), .i_data(cur_vec[7:0]), .o_vld(ov[3]), .o_data(od3));
    cm_sort #(.DCNT(4), .DWIDTH(16), .REG_CNT(4)) u_d4r4 (
        .i_clk(clk), .i_rst(rst), .i_vld(cur_vld), .i_data(cur_vec[3:0]), .o_vld(ov[4]), .o_data(od4));

    assign out_flat[0] = {96'd0, od0};
    assign out_flat[1] = {64'd0, od1};
    assign out_flat[2] = od2;
    assign out_flat[3] = {32'd0, od3};
    assign out_flat[4] = {96'd0, od4};

    function automatic vec_t v8(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
        vec_t r;
        r = '0;
        r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
        r[4] = e4; r[5] = e5; r[6] = e6; r[7] = e7;
        return r;
    endfunction

    // Reference: plain insertion sort of the first d elements.
    function automatic vec_t ref_sort(input vec_t v, input int d);
        int   tmp [10];
        int   key;
        int   b;
        vec_t r;
        r = '0;
        for (int k = 0; k < d; k++) tmp[k] = int'(v[k]);
        for (int a = 1; a < d; a++) begin
            key = tmp[a];
            b = a - 1;
            while (b >= 0 && tmp[b] > key) begin
                tmp[b+1] = tmp[b];
                b--;
            end
            tmp[b+1] = key;
        end
        for (int k = 0; k < d; k++) r[k] = 16'(tmp[k]);
        return r;
    endfunction

    // Compare the first d elements of instance i against an expected vector.
    task automatic cmp_data(input string nm, input int i, input vec_t expv);
        int first_bad;
        first_bad = -1;
        for (int k = DC[i] - 1; k >= 0; k--)
            if (out_flat[i][k*16 +: 16] !== expv[k]) first_bad = k;
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s inst%0d cyc%0d elem%0d got=%h want=%h", nm, i, pcnt, first_bad,
                     out_flat[i][first_bad*16 +: 16], expv[first_bad]);
        end
    endtask

    task automatic cmp_vld(input string nm, input int i, input logic want);
        total++;
        if (ov[i] !== want) begin
            bad++;
            $display("FAIL %s inst%0d cyc%0d o_vld got=%b want=%b", nm, i, pcnt, ov[i], want);
        end
    endtask

    // Scoreboard: output now must be the input presented RC cycles ago.
    task automatic check_sb();
        int   n;
        logic ev;
        for (int i = 0; i < NI; i++) begin
            n = pcnt - RC[i] + 1;
            ev = (n >= 1) ? hist_vld[n] : 1'b0;
            cmp_vld("sb_vld", i, ev);
            if (ev) cmp_data("sb_data", i, ref_sort(hist_vec[n], DC[i]));
        end
    endtask

    // One cycle: check at the falling edge, then drive the next inputs.
    task automatic step(input logic v, input vec_t d, input logic r);
        @(negedge clk);
        check_sb();
        rst = r;
        cur_vld = v;
        cur_vec = d;
        hist_vld[pcnt+1] = v && r;
        hist_vec[pcnt+1] = d;
    endtask

    tvec_t tbl [6];
    vec_t  seq_exp [3];
    vec_t  rv;
    logic  rvld;

    initial begin
        for (int k = 0; k < HN; k++) begin
            hist_vld[k] = 1'b0;
            hist_vec[k] = '0;
        end

        tbl[0] = '{0, v8(16'd5, 16'd3, 16'd9, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0),
                      v8(16'd1, 16'd3, 16'd5, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0)};
        tbl[1] = '{1, v8(16'hFFFF, 16'd7, 16'd7, 16'd0, 16'h8000, 16'd7, 16'd0, 16'd0),
                      v8(16'd0, 16'd7, 16'd7, 16'd7, 16'h8000, 16'hFFFF, 16'd0, 16'd0)};
        tbl[2] = '{3, v8(16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0),
                      v8(16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7)};
        tbl[3].inst = 2;
        tbl[3].in_v = {10{16'hFFFF}};
        tbl[3].in_v[9] = 16'h0000;
        tbl[3].exp_v = {10{16'hFFFF}};
        tbl[3].exp_v[0] = 16'h0000;
        tbl[4] = '{4, v8(16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0),
                      v8(16'd1, 16'd1, 16'd2, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0)};
        tbl[5] = '{0, '0, '0};

        // Reset state between edges.
        #3;
        for (int i = 0; i < NI; i++) begin
            cmp_vld("rst_vld", i, 1'b0);
            cmp_data("rst_data", i, '0);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);

        // Idle after reset: nothing should emerge.
        for (int c = 0; c < 20; c++) step(1'b0, '0, 1'b1);

        // Directed single-pulse vectors.
        for (int t = 0; t < 6; t++) begin
            step(1'b1, tbl[t].in_v, 1'b1);
            for (int c = 0; c < RC[tbl[t].inst]; c++) step(1'b0, '0, 1'b1);
            cmp_vld("tbl_vld", tbl[t].inst, 1'b1);
            cmp_data("tbl_data", tbl[t].inst, tbl[t].exp_v);
        end
        for (int c = 0; c < 5; c++) step(1'b0, '0, 1'b1);

        // Back-to-back: ascending, descending, constant.
        seq_exp[0] = v8(16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7);
        seq_exp[1] = seq_exp[0];
        seq_exp[2] = {10{16'h1234}};
        step(1'b1, v8(16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7), 1'b1);
        step(1'b1, v8(16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0), 1'b1);
        step(1'b1, {10{16'h1234}}, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, 1'b1);
            cmp_vld("b2b_vld", 3, 1'b1);
            cmp_data("b2b_data", 3, seq_exp[k]);
        end
        step(1'b0, '0, 1'b1);
        cmp_vld("b2b_end", 3, 1'b0);

        // Randomised traffic with duplicates and extreme values.
        for (int c = 0; c < 400; c++) begin
            rvld = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 10; k++) begin
                case ($urandom_range(0, 3))
                    0: rv[k] = 16'($urandom_range(0, 3));
                    1: rv[k] = 16'hFFFF;
                    default: rv[k] = 16'($urandom);
                endcase
            end
            step(rvld, rv, 1'b1);
        end

        // Asynchronous reset with vectors in flight.
        step(1'b1, v8(16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2), 1'b1);
        step(1'b1, v8(16'd4, 16'd3, 16'd2, 16'd1, 16'd9, 16'd9, 16'd9, 16'd9), 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cur_vld = 1'b0;
        #1;
        for (int k = 0; k <= pcnt + 1 && k < HN; k++) hist_vld[k] = 1'b0;
        for (int i = 0; i < NI; i++) begin
            cmp_vld("arst_vld", i, 1'b0);
            cmp_data("arst_data", i, '0);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        for (int c = 0; c < 20; c++) step(1'b0, '0, 1'b1);

        // Recovery after reset.
        step(1'b1, tbl[0].in_v, 1'b1);
        step(1'b0, '0, 1'b1);
        cmp_vld("rec_vld", 0, 1'b1);
        cmp_data("rec_data", 0, tbl[0].exp_v);
        for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
